// File: rtl/io_port_arbiter.sv
// Round-robin write arbiter onto the io filter message ports, plus one-entry
// capture mailboxes for the messages coming back from the filter.
module io_port_arbiter #(
  parameter int CORES      = 4,
  parameter int IO_PINS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSEL_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CORES-1:0]                     req_valid,
  input  logic [CORES*PSEL_WIDTH-1:0]          req_port,
  input  logic [CORES*DATA_WIDTH-1:0]          req_data,
  output logic [CORES-1:0]                     req_grant,
  output logic [IO_PINS+1:0]                   port_active_out,
  output logic [(IO_PINS+2)*DATA_WIDTH-1:0]    port_data_out,
  input  logic [IO_PINS+1:0]                   port_active_in,
  input  logic [(IO_PINS+2)*DATA_WIDTH-1:0]    port_data_in,
  output logic [IO_PINS+1:0]                   mbox_full,
  output logic [(IO_PINS+2)*DATA_WIDTH-1:0]    mbox_data,
  input  logic [IO_PINS+1:0]                   mbox_pop,
  output logic [IO_PINS+1:0]                   overflow,
  output logic                                 bad_port
);

  localparam int P     = IO_PINS + 2;
  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [P-1:0]            port_active_q, port_active_d;
  logic [P*DATA_WIDTH-1:0] port_data_q, port_data_d;
  logic [P-1:0]            mbox_full_q, mbox_full_d;
  logic [P*DATA_WIDTH-1:0] mbox_data_q, mbox_data_d;
  logic [P-1:0]            overflow_q, overflow_d;
  logic                    bad_port_q, bad_port_d;

  logic                    gnt_found;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        cand;
  logic [PSEL_WIDTH-1:0]   gnt_port;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic                    port_ok;

  // Modular add that also works when CORES is not a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= CORES) s = s - CORES;
    return s[PTR_W-1:0];
  endfunction

  // Grant is suppressed while rst is high so nothing is consumed during reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_grant = '0;
    for (int i = 0; i < CORES; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (rst) gnt_found = 1'b0;
    if (gnt_found) req_grant[gnt_idx] = 1'b1;
    gnt_port = req_port[int'(gnt_idx)*PSEL_WIDTH +: PSEL_WIDTH];
    gnt_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    port_ok  = int'(gnt_port) < P;
  end

  always_comb begin
    port_active_d = '0;
    port_data_d   = '0;
    ptr_d         = ptr_q;
    bad_port_d    = bad_port_q;
    if (gnt_found) begin
      ptr_d = wrap_add(gnt_idx, 1);
      if (!port_ok) bad_port_d = 1'b1;
      for (int p = 0; p < P; p++) begin
        if (port_ok && int'(gnt_port) == p) begin
          port_active_d[p]                       = 1'b1;
          port_data_d[p*DATA_WIDTH +: DATA_WIDTH] = gnt_data;
        end
      end
    end
  end

  // A strobe always wins over a pop; the pop only matters for overflow then.
  always_comb begin
    mbox_full_d = mbox_full_q;
    mbox_data_d = mbox_data_q;
    overflow_d  = overflow_q;
    for (int p = 0; p < P; p++) begin
      if (port_active_in[p]) begin
        mbox_data_d[p*DATA_WIDTH +: DATA_WIDTH] = port_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        mbox_full_d[p] = 1'b1;
        if (mbox_full_q[p] && !mbox_pop[p]) overflow_d[p] = 1'b1;
      end else if (mbox_pop[p]) begin
        mbox_full_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ptr_q         <= '0;
      port_active_q <= '0;
      port_data_q   <= '0;
      mbox_full_q   <= '0;
      // NOTE: mailbox storage is reset too, because its contents are directly visible on mbox_data.
      mbox_data_q   <= '0;
      overflow_q    <= '0;
      bad_port_q    <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      port_active_q <= port_active_d;
      port_data_q   <= port_data_d;
      mbox_full_q   <= mbox_full_d;
      mbox_data_q   <= mbox_data_d;
      overflow_q    <= overflow_d;
      bad_port_q    <= bad_port_d;
    end
  end

  assign port_active_out = port_active_q;
  assign port_data_out   = port_data_q;
  assign mbox_full       = mbox_full_q;
  assign mbox_data       = mbox_data_q;
  assign overflow        = overflow_q;
  assign bad_port        = bad_port_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed and randomized bench for io_port_arbiter against an array-based
// model of the arbitration, strobe and mailbox rules.
module tb_io_port_arbiter;

  localparam int C  = 4;
  localparam int NP = 6;
  localparam int DW = 8;
  localparam int SW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [C-1:0]         req_valid;
  logic [C*SW-1:0]      req_port;
  logic [C*DW-1:0]      req_data;
  logic [C-1:0]         req_grant;
  logic [NP-1:0]        port_active_out;
  logic [NP*DW-1:0]     port_data_out;
  logic [NP-1:0]        port_active_in;
  logic [NP*DW-1:0]     port_data_in;
  logic [NP-1:0]        mbox_full;
  logic [NP*DW-1:0]     mbox_data;
  logic [NP-1:0]        mbox_pop;
  logic [NP-1:0]        overflow;
  logic                 bad_port;

  io_port_arbiter #(.CORES(C), .IO_PINS(NP-2), .DATA_WIDTH(DW), .PSEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_port(req_port), .req_data(req_data), .req_grant(req_grant),
    .port_active_out(port_active_out), .port_data_out(port_data_out),
    .port_active_in(port_active_in), .port_data_in(port_data_in),
    .mbox_full(mbox_full), .mbox_data(mbox_data), .mbox_pop(mbox_pop),
    .overflow(overflow), .bad_port(bad_port)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit consume  = 1'b1;
  int last_g;

  // Reference model state
  int m_ptr;
  int m_act [NP];
  int m_pd  [NP];
  int m_full[NP];
  int m_md  [NP];
  int m_ovf [NP];
  int m_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int core_port(input int c);
    logic [C*SW-1:0] v;
    v = req_port;
    return int'(v[c*SW +: SW]);
  endfunction

  function automatic int core_data(input int c);
    logic [C*DW-1:0] v;
    v = req_data;
    return int'(v[c*DW +: DW]);
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < C; i++) begin
      int c;
      c = (m_ptr + i) % C;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    if (rst) begin
      m_ptr = 0; m_bad = 0;
      for (int p = 0; p < NP; p++) begin
        m_act[p] = 0; m_pd[p] = 0; m_full[p] = 0; m_md[p] = 0; m_ovf[p] = 0;
      end
      return;
    end
    for (int p = 0; p < NP; p++) begin m_act[p] = 0; m_pd[p] = 0; end
    if (g >= 0) begin
      int k;
      m_ptr = (g + 1) % C;
      k = core_port(g);
      if (k < NP) begin m_act[k] = 1; m_pd[k] = core_data(g); end
      else m_bad = 1;
    end
    for (int p = 0; p < NP; p++) begin
      if (port_active_in[p]) begin
        if (m_full[p] != 0 && !mbox_pop[p]) m_ovf[p] = 1;
        m_md[p]   = int'(port_data_in[p*DW +: DW]);
        m_full[p] = 1;
      end else if (mbox_pop[p]) begin
        m_full[p] = 0;
      end
    end
  endtask

  task automatic check_regs();
    logic [NP-1:0]    ea, ef, eo;
    logic [NP*DW-1:0] ed, em;
    for (int p = 0; p < NP; p++) begin
      ea[p] = (m_act[p] != 0);
      ef[p] = (m_full[p] != 0);
      eo[p] = (m_ovf[p] != 0);
      ed[p*DW +: DW] = 8'(m_pd[p]);
      em[p*DW +: DW] = 8'(m_md[p]);
    end
    check("port_active_out", port_active_out, ea);
    check("port_data_out", port_data_out, ed);
    check("mbox_full", mbox_full, ef);
    check("mbox_data", mbox_data, em);
    check("overflow", overflow, eo);
    check("bad_port", bad_port, m_bad != 0);
  endtask

  // One clock: check combinational grant, advance model, check registered outputs.
  task automatic cycle();
    int g;
    logic [C-1:0] eg;
    #2;
    g  = rst ? -1 : model_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("req_grant", req_grant, eg);
    model_step(g);
    @(posedge clk);
    #1;
    check_regs();
    last_g = g;
    if (consume) begin
      if (g >= 0) req_valid[g] = 1'b0;
      port_active_in = '0;
      mbox_pop       = '0;
    end
  endtask

  task automatic set_req(input int c, input int port, input int data);
    req_valid[c]          = 1'b1;
    req_port[c*SW +: SW]  = 3'(port);
    req_data[c*DW +: DW]  = 8'(data);
  endtask

  task automatic strobe_in(input int p, input int data, input bit pop);
    port_active_in[p]          = 1'b1;
    port_data_in[p*DW +: DW]   = 8'(data);
    mbox_pop[p]                = pop;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_port = '0; req_data = '0;
    port_active_in = '0; port_data_in = '0; mbox_pop = '0;
    model_step(-1);
    @(posedge clk); #1;

    // Reset and idle
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    check("idle_outputs", {port_active_out, mbox_full, overflow, bad_port}, '0);

    // Single write
    set_req(2, 2, 8'hFF);
    #2; check("single_grant", req_grant, 4'b0100);
    cycle();
    check("single_strobe", port_active_out, 6'b000100);
    check("single_data", port_data_out, 48'h0000_00FF_0000);
    cycle();
    check("single_after", port_active_out, 6'b000000);

    // Round robin from a fresh pointer
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int c = 0; c < C; c++) set_req(c, 4, c + 1);
    for (int k = 0; k < C; k++) begin
      cycle();
      check("rr_grant_order", last_g, k);
      check("rr_strobe", port_active_out, 6'b010000);
      check("rr_data", port_data_out[4*DW +: DW], k + 1);
    end
    set_req(0, 1, 8'h11);
    set_req(3, 3, 8'h33);
    #2; check("rr_wrap", req_grant, 4'b0001);
    cycle(); cycle();
    check("rr_second", last_g, 3);

    // Bad port
    set_req(1, 7, 8'hAB);
    #2; check("bad_grant", req_grant, 4'b0010);
    cycle();
    check("bad_no_strobe", port_active_out, 6'b0);
    check("bad_flag", bad_port, 1'b1);
    repeat (3) cycle();
    check("bad_sticky", bad_port, 1'b1);

    // Mailbox fill, overflow, strobe+pop, pop
    strobe_in(5, 8'h3C, 1'b0); cycle();
    check("mb_full", mbox_full[5], 1'b1);
    check("mb_data", mbox_data[5*DW +: DW], 8'h3C);
    strobe_in(5, 8'h5A, 1'b0); cycle();
    check("mb_ovf_data", mbox_data[5*DW +: DW], 8'h5A);
    check("mb_ovf", overflow[5], 1'b1);
    strobe_in(5, 8'h77, 1'b1); cycle();
    check("mb_pop_strobe", {mbox_full[5], mbox_data[5*DW +: DW]}, 9'h177);
    mbox_pop[5] = 1'b1; cycle();
    check("mb_pop", mbox_full[5], 1'b0);
    check("mb_pop_ovf", overflow[5], 1'b1);
    mbox_pop[0] = 1'b1; cycle();
    check("mb_pop_empty", mbox_full[0], 1'b0);

    // Reset mid-operation
    strobe_in(0, 8'h42, 1'b0);
    set_req(3, 0, 8'h99);
    cycle();
    check("mid_full0", mbox_full[0], 1'b1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("mid_clear", {port_active_out, mbox_full, overflow, bad_port}, '0);
    for (int c = 0; c < C; c++) set_req(c, 1, 8'h10 + c);
    #2; check("mid_restart", req_grant, 4'b0001);
    repeat (C) cycle();

    // Randomized phase
    consume = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 39) == 0);
      req_valid      = 4'($urandom);
      for (int c = 0; c < C; c++) req_port[c*SW +: SW] = 3'($urandom_range(0, 7));
      req_data       = $urandom;
      port_active_in = 6'($urandom);
      port_data_in   = {16'($urandom), $urandom};
      mbox_pop       = 6'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_port_arbiter.md
Name: io_port_arbiter

Overview:
- Shares the IO_PINS+2 message ports of the io filter between CORES requesters (cpu cores / memory-side agents).
- Write side: round-robin arbiter that grants one requester per cycle and turns the grant into a registered one-cycle port_active_out pulse with data on the selected port slice.
- Read side: one-entry mailbox per port that captures port_active_in pulses and holds them until popped, with sticky overflow flags.

Parameters:
- CORES, 4, number of requesters.
- IO_PINS, 4, io pins; the port count is P = IO_PINS+2.
- DATA_WIDTH, 8, message width.
- PSEL_WIDTH, 3, port-select width; must satisfy 2^PSEL_WIDTH >= IO_PINS+2.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  CORES  per-core write request.
- req_port  in  CORES*PSEL_WIDTH  per-core target port index, core c at [c*PSEL_WIDTH +: PSEL_WIDTH].
- req_data  in  CORES*DATA_WIDTH  per-core payload.
- req_grant  out  CORES  one-hot grant; the request is consumed in the cycle req_grant is high.
- port_active_out  out  P  one-cycle strobe to the io filter.
- port_data_out  out  P*DATA_WIDTH  payload slices to the io filter.
- port_active_in  in  P  one-cycle strobes from the io filter.
- port_data_in  in  P*DATA_WIDTH  payload slices from the io filter.
- mbox_full  out  P  mailbox p holds unread data.
- mbox_data  out  P*DATA_WIDTH  mailbox contents.
- mbox_pop  in  P  consumer pop strobes.
- overflow  out  P  sticky: mailbox p was overwritten while full.
- bad_port  out  1  sticky: a granted request had req_port >= P.

Behaviour:
- Reset (rst=1 at an edge): req_grant=0, port_active_out=0, port_data_out=0, mbox_full=0, mbox_data=0, overflow=0, bad_port=0, rr pointer=0. Reset overrides all same-cycle events; in-flight strobes are dropped.
- Arbitration:
  - Combinational, same cycle.
  - Search req_valid starting at index ptr, ascending modulo CORES; the first set bit wins and req_grant is one-hot on it.
  - No request: req_grant=0 and ptr is unchanged.
  - On a grant to core g: ptr <= (g+1) mod CORES.
  - A requester holds req_valid, req_port and req_data stable until granted. The arbiter must not depend on this.
- Write output, latency 1:
  - A grant at cycle t with req_port = k < P gives port_active_out = (1<<k) during cycle t+1.
  - port_data_out slice k = req_data of g during cycle t+1; all other slices = 0.
  - With no grant at cycle t, port_active_out and port_data_out are 0 at t+1.
  - Back-to-back grants give back-to-back single-cycle strobes. Throughput is one message per cycle.
- Bad port:
  - A grant with req_port >= P still consumes the request (grant asserted, ptr advances).
  - No strobe is produced.
  - bad_port <= 1, sticky until rst.
- Mailbox p, evaluated at each edge:
  - port_active_in[p]=1 and mbox_full[p]=0: mbox_data[p] <= port_data_in[p], full <= 1.
  - port_active_in[p]=1, full=1, mbox_pop[p]=1: store new data, full stays 1, no overflow.
  - port_active_in[p]=1, full=1, mbox_pop[p]=0: store new data (newest wins), overflow[p] <= 1.
  - port_active_in[p]=0 and mbox_pop[p]=1: full <= 0. mbox_data keeps its value.
  - mbox_pop on an empty mailbox is ignored and is not an error.
- Capture latency: mbox_full and mbox_data are visible in the cycle after the strobe.
- Mailboxes are independent; all P may capture in the same cycle.
- Write and read paths are independent. There is no loop-back path inside the block.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, then idle inputs -> every output stays 0, no strobes.
- Single write: core 2 requests port 2 with data 0xFF -> req_grant=0100 in the same cycle; next cycle port_active_out=000100, port_data_out slice 2 = 0xFF, all other slices 0; following cycle all zeros.
- Round robin: all 4 cores hold requests to port 4 with data 0x01..0x04 -> grants 0,1,2,3 on consecutive cycles; port_active_out=010000 for 4 consecutive cycles with data 0x01,0x02,0x03,0x04. Then core 0 and core 3 re-request -> core 0 is granted first (ptr wrapped to 0).
- Bad port: core 1 requests port 7 -> req_grant=0010, no strobe, bad_port=1 and stays 1 until rst.
- Mailbox fill, pop and overflow:
  - Strobe port 5 with 0x3C -> next cycle mbox_full[5]=1, mbox_data slice 5 = 0x3C.
  - Strobe 0x5A with no pop -> data 0x5A, overflow[5]=1.
  - Strobe 0x77 together with mbox_pop[5] -> data 0x77, full=1, overflow unchanged.
  - Pop alone -> full=0.
- Reset mid-operation: assert rst in the cycle after a grant, with mailbox 0 full -> no strobe appears, mbox_full=0, overflow=0, bad_port=0; the next grant starts from core 0.
